wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 107 ++++++++++
 tb/tb_wb_regfile.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Pipeline register file with write-back mux, same-cycle write-through
//   bypass on both read ports, a non-bypassed debug read port and a
//   committed-write counter.
//
// Ports
//   Clk           in   rising-edge clock
//   Rst_n         in   asynchronous active-low reset (clears regs + counter)
//   WBRegWrite    in   write-back enable from MEM/WB
//   WBMemtoReg    in   1 = write memory data, 0 = write ALU result
//   WBMemData     in   load data from MEM/WB
//   WBALUResult   in   ALU result from MEM/WB
//   WBRegisterRd  in   destination register index
//   ReadReg1/2    in   ID-stage source indices (rs / rt)
//   ReadData1/2   out  source operands, bypassed from write-back
//   WBWriteData   out  selected write-back value (also feeds EX forwarding)
//   DbgAddr       in   debug read index
//   DbgData       out  committed register contents, no bypass
//   WriteCount    out  number of committed register writes (wraps)
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WBRegWrite,
  input  logic              WBMemtoReg,
  input  logic [DATA_W-1:0] WBMemData,
  input  logic [DATA_W-1:0] WBALUResult,
  input  logic [ADDR_W-1:0] WBRegisterRd,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WBWriteData,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData,
  output logic [31:0]       WriteCount
);

  localparam int NREG = 1 << ADDR_W;

  logic              w_wr_en;
  logic              w_bypass_en;
  logic [DATA_W-1:0] w_reg_val [NREG];
  logic [31:0]       r_write_count;

  // Write-back mux stays live during reset so the EX forwarding path is
  // never disturbed by the register file's reset state.
  assign WBWriteData = WBMemtoReg ? WBMemData : WBALUResult;

  // Index 0 is hard-wired zero, so a write to it is neither stored nor counted.
  assign w_wr_en = WBRegWrite && (WBRegisterRd != '0);

  // The bypass is gated by reset so all read ports show zero while Rst_n=0.
  assign w_bypass_en = w_wr_en && Rst_n;

  // One storage element per register; element 0 has no storage at all.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_reg_val[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] r_data;

        always_ff @(posedge Clk or negedge Rst_n) begin
          if (!Rst_n) begin
            r_data <= '0;
          end else if (w_wr_en && (WBRegisterRd == ADDR_W'(gi))) begin
            r_data <= WBWriteData;
          end
        end

        assign w_reg_val[gi] = r_data;
      end
    end
  endgenerate

  // Read ports: index 0 reads zero, a matching in-flight write is forwarded,
  // otherwise the stored value is returned. Both ports use identical logic,
  // so rs == rt always yields the same value on both.
  assign ReadData1 = (ReadReg1 == '0) ? '0 :
                     (w_bypass_en && (ReadReg1 == WBRegisterRd)) ? WBWriteData :
                     w_reg_val[ReadReg1];

  assign ReadData2 = (ReadReg2 == '0) ? '0 :
                     (w_bypass_en && (ReadReg2 == WBRegisterRd)) ? WBWriteData :
                     w_reg_val[ReadReg2];

  // Debug port shows committed state only.
  assign DbgData = w_reg_val[DbgAddr];

  // Counter wraps naturally at 2**32.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_write_count <= '0;
    end else if (w_wr_en) begin
      r_write_count <= r_write_count + 32'd1;
    end
  end

  assign WriteCount = r_write_count;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed self-checking bench for wb_regfile. Inputs change on the falling
//   edge, writes commit on the rising edge, outputs are sampled 1 ns after
//   the input change (combinational) or after the following falling edge.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        Clk;
  logic        Rst_n;
  logic        WBRegWrite;
  logic        WBMemtoReg;
  logic [31:0] WBMemData;
  logic [31:0] WBALUResult;
  logic [4:0]  WBRegisterRd;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WBWriteData;
  logic [4:0]  DbgAddr;
  logic [31:0] DbgData;
  logic [31:0] WriteCount;

  int n_tests = 0;
  int n_fail  = 0;

  wb_regfile #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .WBRegWrite   (WBRegWrite),
    .WBMemtoReg   (WBMemtoReg),
    .WBMemData    (WBMemData),
    .WBALUResult  (WBALUResult),
    .WBRegisterRd (WBRegisterRd),
    .ReadReg1     (ReadReg1),
    .ReadReg2     (ReadReg2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .WBWriteData  (WBWriteData),
    .DbgAddr      (DbgAddr),
    .DbgData      (DbgData),
    .WriteCount   (WriteCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // One write-back cycle; returns at the next falling edge with the write off.
  task automatic wb_write(input logic [4:0] rd, input logic mem2reg,
                          input logic [31:0] mem, input logic [31:0] alu);
    @(negedge Clk);
    WBRegWrite   = 1'b1;
    WBRegisterRd = rd;
    WBMemtoReg   = mem2reg;
    WBMemData    = mem;
    WBALUResult  = alu;
    @(negedge Clk);
    WBRegWrite   = 1'b0;
    #1;
  endtask

  initial begin
    // ---------------- reset behaviour ----------------
    Rst_n        = 1'b0;
    WBRegWrite   = 1'b1;
    WBMemtoReg   = 1'b0;
    WBMemData    = 32'h0;
    WBALUResult  = 32'h0000_AAAA;
    WBRegisterRd = 5'd5;
    ReadReg1     = 5'd5;
    ReadReg2     = 5'd5;
    DbgAddr      = 5'd5;
    #2;
    check_value("rst_rd1_no_bypass", ReadData1, 32'h0);
    check_value("rst_rd2_no_bypass", ReadData2, 32'h0);
    check_value("rst_wbdata_mux", WBWriteData, 32'h0000_AAAA);
    check_value("rst_count", WriteCount, 32'h0);
    @(posedge Clk);
    #1;
    check_value("rst_write_ignored", DbgData, 32'h0);
    check_value("rst_count_after_edge", WriteCount, 32'h0);
    @(negedge Clk);
    WBRegWrite = 1'b0;
    Rst_n      = 1'b1;

    // ---------------- basic write then read ----------------
    wb_write(5'd5, 1'b0, 32'hFFFF_0000, 32'h1234_5678);
    ReadReg1 = 5'd5;
    DbgAddr  = 5'd5;
    #1;
    check_value("basic_rd1", ReadData1, 32'h1234_5678);
    check_value("basic_dbg5", DbgData, 32'h1234_5678);
    check_value("basic_count", WriteCount, 32'd1);

    // ---------------- bypass ----------------
    @(negedge Clk);
    WBRegWrite   = 1'b1;
    WBRegisterRd = 5'd7;
    WBMemtoReg   = 1'b1;
    WBMemData    = 32'hDEAD_BEEF;
    WBALUResult  = 32'h1111_1111;
    ReadReg1     = 5'd7;
    ReadReg2     = 5'd7;
    DbgAddr      = 5'd7;
    #1;
    check_value("byp_wbdata", WBWriteData, 32'hDEAD_BEEF);
    check_value("byp_rd1", ReadData1, 32'hDEAD_BEEF);
    check_value("byp_rd2", ReadData2, 32'hDEAD_BEEF);
    check_value("byp_dbg7_old", DbgData, 32'h0);
    @(negedge Clk);
    WBRegWrite = 1'b0;
    #1;
    check_value("byp_dbg7_committed", DbgData, 32'hDEAD_BEEF);
    check_value("byp_rd1_stored", ReadData1, 32'hDEAD_BEEF);
    check_value("byp_count", WriteCount, 32'd2);

    // ---------------- register 0 ----------------
    @(negedge Clk);
    WBRegWrite   = 1'b1;
    WBRegisterRd = 5'd0;
    WBMemtoReg   = 1'b0;
    WBALUResult  = 32'hFFFF_FFFF;
    ReadReg1     = 5'd0;
    ReadReg2     = 5'd0;
    DbgAddr      = 5'd0;
    #1;
    check_value("r0_rd1_no_bypass", ReadData1, 32'h0);
    check_value("r0_rd2_no_bypass", ReadData2, 32'h0);
    @(negedge Clk);
    WBRegWrite = 1'b0;
    #1;
    check_value("r0_dbg", DbgData, 32'h0);
    check_value("r0_count_unchanged", WriteCount, 32'd2);

    // ---------------- disabled writes ----------------
    wb_write(5'd3, 1'b0, 32'h0, 32'h3333_0003);
    check_value("dis_count_before", WriteCount, 32'd3);
    ReadReg1 = 5'd3;
    ReadReg2 = 5'd5;
    DbgAddr  = 5'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      WBRegWrite   = 1'b0;
      WBRegisterRd = 5'd3;
      WBMemtoReg   = i[0];
      WBMemData    = $urandom;
      WBALUResult  = $urandom;
      #1;
      check_value($sformatf("dis_rd1_cyc%0d", i), ReadData1, 32'h3333_0003);
    end
    @(negedge Clk);
    #1;
    check_value("dis_dbg3", DbgData, 32'h3333_0003);
    check_value("dis_rd2_reg5", ReadData2, 32'h1234_5678);
    check_value("dis_count_after", WriteCount, 32'd3);

    // ---------------- counter wrap ----------------
    @(negedge Clk);
    force dut.r_write_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_write_count;
    #1;
    check_value("wrap_preset", WriteCount, 32'hFFFF_FFFE);
    wb_write(5'd10, 1'b0, 32'h0, 32'h0000_000A);
    check_value("wrap_1", WriteCount, 32'hFFFF_FFFF);
    wb_write(5'd11, 1'b1, 32'h0000_000B, 32'h0);
    check_value("wrap_2", WriteCount, 32'h0);
    wb_write(5'd12, 1'b0, 32'h0, 32'h0000_000C);
    check_value("wrap_3", WriteCount, 32'd1);
    DbgAddr = 5'd11;
    #1;
    check_value("wrap_dbg11_memdata", DbgData, 32'h0000_000B);

    // ---------------- asynchronous reset ----------------
    for (int r = 1; r < 32; r++) begin
      wb_write(5'(r), 1'b0, 32'h0, 32'(r));
    end
    for (int r = 1; r < 32; r++) begin
      DbgAddr = 5'(r);
      #1;
      if (DbgData !== 32'(r))
        check_value($sformatf("fill_dbg%0d", r), DbgData, 32'(r));
    end
    DbgAddr = 5'd31;
    #1;
    check_value("fill_dbg31", DbgData, 32'd31);
    @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #0.5;
    check_value("arst_count", WriteCount, 32'h0);
    for (int r = 0; r < 32; r++) begin
      DbgAddr = 5'(r);
      #0.1;
      if (DbgData !== 32'h0)
        check_value($sformatf("arst_dbg%0d", r), DbgData, 32'h0);
    end
    DbgAddr = 5'd9;
    ReadReg1 = 5'd9;
    ReadReg2 = 5'd31;
    WBRegWrite   = 1'b1;
    WBRegisterRd = 5'd9;
    WBMemtoReg   = 1'b0;
    WBALUResult  = 32'h0000_0042;
    #0.1;
    check_value("arst_dbg9", DbgData, 32'h0);
    check_value("arst_rd1_no_bypass", ReadData1, 32'h0);
    check_value("arst_rd2_reg31", ReadData2, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    WBRegWrite = 1'b0;
    #1;
    check_value("post_rst_dbg9", DbgData, 32'h0000_0042);
    check_value("post_rst_count", WriteCount, 32'd1);

    // ---------------- reset in the middle of a write cycle ----------------
    @(negedge Clk);
    WBRegWrite   = 1'b1;
    WBRegisterRd = 5'd4;
    WBMemtoReg   = 1'b0;
    WBALUResult  = 32'h0000_0055;
    DbgAddr      = 5'd4;
    #2;
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    WBRegWrite = 1'b0;
    check_value("midrst_count", WriteCount, 32'h0);
    check_value("midrst_dbg4", DbgData, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    #1;
    check_value("midrst_dbg4_after", DbgData, 32'h0);
    check_value("midrst_count_after", WriteCount, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case anything above ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
